// File: rtl/mem_subsystem.sv
// MAR/MDR plus word RAM; an accepted read or write completes WAIT_STATES+1 edges later, then done pulses.
// No backpressure: a request while busy, or a write paired with a read, is dropped and latched in overrun.
module mem_subsystem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  mari,
    input  logic                  mdri,
    input  logic                  mdro,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic [ADDR_WIDTH-1:0] mar_q,
    output logic [DATA_WIDTH-1:0] mdr_q,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
    logic                  rd_done, wr_done, drop;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
        end
    end

    // Requests snapshot the pre-edge MAR/MDR, so same-edge mari/mdri loads do not leak in.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read) begin
                    state_nxt = RD_WAIT;
                    cnt_nxt   = CNT_INIT;
                    addr_nxt  = mar_q;
                    drop      = mem_write;
                end else if (mem_write) begin
                    state_nxt = WR_WAIT;
                    cnt_nxt   = CNT_INIT;
                    addr_nxt  = mar_q;
                    wdata_nxt = mdr_q;
                end
            end
            RD_WAIT, WR_WAIT: begin
                drop = mem_read | mem_write;
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                    rd_done   = (state == RD_WAIT);
                    wr_done   = (state == WR_WAIT);
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mar_q   <= '0;
            mdr_q   <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (mari)
                mar_q <= bus_in[ADDR_WIDTH-1:0];
            if (rd_done)
                mdr_q <= mem[addr_q];
            else if (mdri)
                mdr_q <= bus_in;
            done    <= rd_done | wr_done;
            overrun <= overrun | drop;
        end
    end

    // Memory contents survive reset; a reset edge also cancels a write landing on that edge.
    always_ff @(posedge clock) begin
        if (!reset && wr_done)
            mem[addr_q] <= wdata_q;
    end

    assign busy    = (state != IDLE);
    assign bus_out = mdro ? mdr_q : '0;
endmodule

// File: tb/tb_mem_subsystem.sv
// Directed and random stimulus for mem_subsystem, checked against a transaction-level model.
module tb_mem_subsystem;
    logic        clock = 1'b0;
    logic        reset, mari, mdri, mdro, mem_read, mem_write;
    logic [31:0] bus_in;

    logic [31:0] bus_out2, mdr2, bus_out0, mdr0, bus_out15, mdr15;
    logic [8:0]  mar2, mar0, mar15;
    logic        busy2, done2, ovr2, busy0, done0, ovr0, busy15, done15, ovr15;

    int n_assert = 0;
    int n_fail   = 0;

    mem_subsystem #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(2)) dut (
        .clock(clock), .reset(reset), .bus_in(bus_in), .mari(mari), .mdri(mdri), .mdro(mdro),
        .mem_read(mem_read), .mem_write(mem_write), .bus_out(bus_out2), .mar_q(mar2),
        .mdr_q(mdr2), .busy(busy2), .done(done2), .overrun(ovr2));

    mem_subsystem #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(0)) dut_ws0 (
        .clock(clock), .reset(reset), .bus_in(bus_in), .mari(mari), .mdri(mdri), .mdro(mdro),
        .mem_read(mem_read), .mem_write(mem_write), .bus_out(bus_out0), .mar_q(mar0),
        .mdr_q(mdr0), .busy(busy0), .done(done0), .overrun(ovr0));

    mem_subsystem #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(15)) dut_ws15 (
        .clock(clock), .reset(reset), .bus_in(bus_in), .mari(mari), .mdri(mdri), .mdro(mdro),
        .mem_read(mem_read), .mem_write(mem_write), .bus_out(bus_out15), .mar_q(mar15),
        .mdr_q(mdr15), .busy(busy15), .done(done15), .overrun(ovr15));

    always #5 clock = ~clock;

    // Transaction-level reference: one pending access that finishes at a known edge number.
    localparam int WS = 2;
    logic [8:0]  m_mar;
    logic [31:0] m_mdr;
    logic        m_done, m_ovr;
    logic [31:0] m_mem [512];
    logic        pend, pend_rd;
    logic [8:0]  pend_addr;
    logic [31:0] pend_data;
    int          pend_end;
    int          edge_no = 0;

    task automatic model_edge();
        logic       completing;
        logic       was_busy;
        logic [8:0] old_mar;
        logic [31:0] old_mdr;
        edge_no++;
        if (reset) begin
            m_mar = '0; m_mdr = '0; m_done = 1'b0; m_ovr = 1'b0; pend = 1'b0;
            return;
        end
        completing = pend && (edge_no == pend_end);
        was_busy   = pend;
        old_mar    = m_mar;
        old_mdr    = m_mdr;
        m_done     = completing;
        if (mari) m_mar = bus_in[8:0];
        if (mdri) m_mdr = bus_in;
        if (completing) begin
            if (pend_rd) m_mdr = m_mem[pend_addr];
            else         m_mem[pend_addr] = pend_data;
            pend = 1'b0;
        end
        if (was_busy) begin
            if (mem_read || mem_write) m_ovr = 1'b1;
        end else if (mem_read || mem_write) begin
            pend      = 1'b1;
            pend_rd   = mem_read;
            pend_addr = old_mar;
            pend_data = old_mdr;
            pend_end  = edge_no + 1 + WS;
            if (mem_read && mem_write) m_ovr = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("mar", 32'(mar2), 32'(m_mar));
        chk("mdr", mdr2, m_mdr);
        chk("busy", 32'(busy2), 32'(pend));
        chk("done", 32'(done2), 32'(m_done));
        chk("overrun", 32'(ovr2), 32'(m_ovr));
        chk("bus_out", bus_out2, mdro ? m_mdr : 32'h0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic drive(input logic rd, input logic wr, input logic mi, input logic di,
                         input logic [31:0] b);
        mem_read = rd; mem_write = wr; mari = mi; mdri = di; bus_in = b;
        step();
        mem_read = 1'b0; mem_write = 1'b0; mari = 1'b0; mdri = 1'b0;
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 40 && pend; g++) step();
        chk("idle_timeout", 32'(busy2), 32'h0);
        step();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        drive(0, 0, 1, 0, a);
        drive(0, 0, 0, 1, d);
        drive(0, 1, 0, 0, 32'h0);
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] a);
        drive(0, 0, 1, 0, a);
        drive(1, 0, 0, 0, 32'h0);
        wait_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        reset = 1'b1; mari = 0; mdri = 0; mdro = 0; mem_read = 0; mem_write = 0; bus_in = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_mar", 32'(mar2), 32'h0);
        chk("rst_mdr", mdr2, 32'h0);
        chk("rst_busy", 32'(busy2), 32'h0);
        chk("rst_done", 32'(done2), 32'h0);
        chk("rst_ovr", 32'(ovr2), 32'h0);

        for (int a = 0; a < 16; a++)
            do_write(32'(a), (a == 9) ? 32'h0 : 32'h1000_0000 + 32'(a));

        // Write/read with 2 wait states
        drive(0, 0, 1, 0, 32'h05);
        drive(0, 0, 0, 1, 32'hDEADBEEF);
        drive(0, 1, 0, 0, 32'h0);
        chk("wr_busy_k", 32'(busy2), 32'h1);
        step(); chk("wr_busy_k1", 32'(busy2), 32'h1);
        step(); chk("wr_busy_k2", 32'(busy2), 32'h1);
        step(); chk("wr_busy_k3", 32'(busy2), 32'h0);
        chk("wr_done_k3", 32'(done2), 32'h1);
        step(); chk("wr_done_k4", 32'(done2), 32'h0);
        drive(0, 0, 0, 1, 32'h0);
        chk("mdr_cleared", mdr2, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        step(); step();
        chk("rd_mdr_early", mdr2, 32'h0);
        step();
        chk("rd_mdr_k3", mdr2, 32'hDEADBEEF);
        chk("rd_done_k3", 32'(done2), 32'h1);
        mdro = 1'b1; #1;
        chk("bus_out_on", bus_out2, 32'hDEADBEEF);
        mdro = 1'b0; #1;
        chk("bus_out_off", bus_out2, 32'h0);
        step();

        // Snapshot isolation
        do_write(32'h3, 32'h11);
        drive(0, 0, 1, 0, 32'h3);
        drive(0, 0, 0, 1, 32'h11);
        drive(0, 1, 0, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h7);
        drive(0, 0, 0, 1, 32'h22);
        wait_idle();
        chk("snap_mdr", mdr2, 32'h22);
        chk("snap_mar", 32'(mar2), 32'h7);
        do_read(32'h7);
        chk("snap_mem7", mdr2, 32'h1000_0007);
        do_read(32'h3);
        chk("snap_mem3", mdr2, 32'h11);

        // Read+write conflict, then completion-edge drop and done-cycle acceptance
        drive(0, 0, 1, 0, 32'h4);
        drive(0, 0, 0, 1, 32'h99);
        drive(1, 1, 0, 0, 32'h0);
        wait_idle();
        chk("conf_mdr", mdr2, 32'h1000_0004);
        chk("conf_ovr", 32'(ovr2), 32'h1);
        drive(0, 0, 0, 1, 32'h0);
        do_read(32'h4);
        chk("conf_nowrite", mdr2, 32'h1000_0004);
        do_reset();
        chk("conf_rst_ovr", 32'(ovr2), 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        step(); step();
        drive(1, 0, 0, 0, 32'h0);
        chk("cedge_ovr", 32'(ovr2), 32'h1);
        chk("cedge_busy", 32'(busy2), 32'h0);
        chk("cedge_done", 32'(done2), 32'h1);
        drive(1, 0, 0, 0, 32'h0);
        chk("donecyc_busy", 32'(busy2), 32'h1);
        wait_idle();

        // Reset in the middle of a write
        drive(0, 0, 1, 0, 32'h9);
        drive(0, 0, 0, 1, 32'hAAAA);
        drive(0, 1, 0, 0, 32'h0);
        step();
        do_reset();
        chk("rstw_busy", 32'(busy2), 32'h0);
        chk("rstw_mar", 32'(mar2), 32'h0);
        chk("rstw_mdr", mdr2, 32'h0);
        chk("rstw_ovr", 32'(ovr2), 32'h0);
        step(); step();
        do_write(32'hC, 32'h1234_5678);
        do_read(32'hC);
        chk("rstw_known", mdr2, 32'h1234_5678);
        do_read(32'h9);
        chk("rstw_mem9", mdr2, 32'h0);

        // Latency sweep across WAIT_STATES = 0 and 15; address aliasing
        do_reset();
        drive(0, 0, 1, 0, 32'hFFFF_F3FF);
        chk("alias_mar2", 32'(mar2), 32'h1FF);
        chk("alias_mar15", 32'(mar15), 32'h1FF);
        drive(0, 0, 0, 1, 32'hC0FFEE01);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) drive(0, 0, 0, 1, 32'h0);
            mem_read = (pass == 1); mem_write = (pass == 0);
            for (int i = 0; i <= 16; i++) begin
                step();
                mem_read = 1'b0; mem_write = 1'b0;
                chk("sw_busy0", 32'(busy0), 32'(i == 0));
                chk("sw_done0", 32'(done0), 32'(i == 1));
                chk("sw_busy15", 32'(busy15), 32'(i < 16));
                chk("sw_done15", 32'(done15), 32'(i == 16));
            end
            step();
        end
        chk("sw_mdr0", mdr0, 32'hC0FFEE01);
        chk("sw_mdr15", mdr15, 32'hC0FFEE01);
        chk("sw_mdr2", mdr2, 32'hC0FFEE01);
        chk("sw_ovr0", 32'(ovr0), 32'h0);
        chk("sw_ovr15", 32'(ovr15), 32'h0);
        mdro = 1'b1; #1;
        chk("sw_bus0", bus_out0, 32'hC0FFEE01);
        chk("sw_bus15", bus_out15, 32'hC0FFEE01);
        mdro = 1'b0;

        // Read-completion edge beats mdri
        do_reset();
        drive(0, 0, 1, 0, 32'h5);
        drive(1, 0, 0, 0, 32'h0);
        step(); step();
        drive(0, 0, 0, 1, 32'h55);
        chk("coll_mdr", mdr2, 32'hDEADBEEF);
        drive(0, 0, 0, 1, 32'h55);
        chk("coll_after", mdr2, 32'h55);

        // Random traffic confined to the initialised addresses 0..15
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            reset     = (r[5:0] == 6'd0);
            mem_read  = (r[8:6] == 3'd0);
            mem_write = (r[11:9] == 3'd0);
            mari      = r[12] & r[13];
            mdri      = r[14];
            mdro      = r[15];
            bus_in    = $urandom & 32'hFFFF_FE0F;
            step();
        end
        reset = 0; mari = 0; mdri = 0; mdro = 0; mem_read = 0; mem_write = 0;
        for (int n = 0; n < 20; n++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
